// File: rtl/arm_alu_wb.sv
// arm_alu_wb: ALU writeback stage. Registers the ALU result as a
// register-file write token and keeps the architectural NZCV flags.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake (ALU operation)
//   alu_y, alu_n/z/c/v  ALU result and raw flags
//   opcode, cond, s_bit ALU opcode, ARM condition, set-flags request
//   shift_c             shifter carry-out (C for logical/test ops)
//   rd                  destination register index
//   out_valid/out_ready downstream handshake (write token)
//   out_data/rd/we      registered result, index, write enable
//   flags, c_to_alu     architectural {N,Z,C,V} and carry to ALU
//   flags_load/flags_in direct flag write, wins over instruction update
module arm_alu_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_y,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic [4:0]  opcode,
  input  logic [3:0]  cond,
  input  logic        s_bit,
  input  logic        shift_c,
  input  logic [3:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_rd,
  output logic        out_we,
  output logic [3:0]  flags,
  output logic        c_to_alu,
  input  logic        flags_load,
  input  logic [3:0]  flags_in
);

  logic        r_valid;
  logic [31:0] r_data;
  logic [3:0]  r_rd;
  logic        r_we;
  logic [3:0]  r_flags;

  logic        w_accept;
  logic        w_pass;
  logic        w_arith;
  logic        w_cmp;
  logic        w_log;
  logic        w_tst;
  logic        w_we;
  logic [3:0]  w_flags_nxt;
  logic        w_n, w_z, w_c, w_v;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  assign in_ready = !r_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_pass = 1'b0;
    unique case (cond)
      4'b0000: w_pass = w_z;
      4'b0001: w_pass = !w_z;
      4'b0010: w_pass = w_c;
      4'b0011: w_pass = !w_c;
      4'b0100: w_pass = w_n;
      4'b0101: w_pass = !w_n;
      4'b0110: w_pass = w_v;
      4'b0111: w_pass = !w_v;
      4'b1000: w_pass = w_c & !w_z;
      4'b1001: w_pass = !w_c | w_z;
      4'b1010: w_pass = (w_n == w_v);
      4'b1011: w_pass = (w_n != w_v);
      4'b1100: w_pass = !w_z & (w_n == w_v);
      4'b1101: w_pass = w_z | (w_n != w_v);
      4'b1110: w_pass = 1'b1;
      4'b1111: w_pass = 1'b0;
    endcase
  end

  assign w_arith = (opcode >= 5'b00010) && (opcode <= 5'b00111);
  assign w_cmp   = (opcode == 5'b01010) || (opcode == 5'b01011);
  assign w_tst   = (opcode == 5'b01000) || (opcode == 5'b01001);
  assign w_log   = (opcode == 5'b00000) || (opcode == 5'b00001)
                || ((opcode >= 5'b01100) && (opcode <= 5'b01111));

  // Compare/test ops only produce flags, never a register write.
  assign w_we = w_pass & !w_cmp & !w_tst;

  always_comb begin
    w_flags_nxt = r_flags;
    if (w_accept && w_pass) begin
      if ((w_arith && s_bit) || w_cmp)
        w_flags_nxt = {alu_n, alu_z, alu_c, alu_v};
      else if ((w_log && s_bit) || w_tst)
        w_flags_nxt = {alu_n, alu_z, shift_c, r_flags[0]};
    end
    // A direct flag write overrides whatever the instruction did.
    if (flags_load)
      w_flags_nxt = flags_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_flags <= '0;
    end else begin
      r_flags <= w_flags_nxt;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= alu_y;
        r_rd    <= rd;
        r_we    <= w_we;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_rd    = r_rd;
  assign out_we    = r_we;
  assign flags     = r_flags;
  assign c_to_alu  = r_flags[1];

endmodule
